aes_round_ctrl: RTL and testbench
=================================

// Module: aes_round_ctrl
// PURPOSE
// - Iterative AES encryption sequencer; sits directly downstream of key_exp and consumes its round keys.
// - Per round: drives kcnt and en to key_exp, waits for done, then updates the 128-bit state register.
//   - Round 0: state ^ w_data.
//   - Rounds 1..NR: rf_result, from the external combinational round function.
// - valid/ready on both the plaintext input and the ciphertext output.
// PARAMETERS
// - NR           10   number of AES rounds; legal values 10, 12, 14 (kcnt is 4 bits)
// - KEY_TIMEOUT  32   max KWAIT cycles before abort; used only when AES_KEY_TIMEOUT_EN is defined
// PORTS
// - clk        in   1    rising-edge clock
// - rst        in   1    asynchronous, active-high reset
// - in_valid   in   1    plaintext offered
// - in_ready   out  1    block idle, can accept plaintext
// - pt         in   128  plaintext, sampled when in_valid && in_ready
// - key_en     out  1    one-cycle round-key request to key_exp (drives its en)
// - kcnt       out  4    round index for key_exp, 0..NR
// - kdone      in   1    key_exp done; w_data is valid while high
// - rkey       in   128  round key from key_exp w_data
// - rf_state   out  128  current state register, to the round function
// - rf_last    out  1    high when kcnt==NR (round function skips MixColumns)
// - rf_result  in   128  round function output = round(rf_state, rkey)
// - out_valid  out  1    ciphertext available
// - out_ready  in   1    consumer accepts ciphertext
// - ct         out  128  ciphertext; equals the state register in DONE
// - err        out  1    key timeout flag; sticky until next accept
// BEHAVIOUR
// - Reset (async): FSM=IDLE, state=0, rnd=0, key_en=0, out_valid=0, err=0. Any FSM state aborts immediately.
// - FSM states: IDLE, KREQ, KWAIT, DONE.
// - IDLE
//   - in_ready=1.
//   - On in_valid: state<=pt, rnd<=0, err<=0 -> KREQ.
// - KREQ
//   - key_en=1 for exactly this one cycle; kcnt=rnd.
//   - kdone is ignored in this cycle (stale done from the prior round); -> KWAIT.
// - KWAIT
//   - key_en=0; kcnt held at rnd.
//   - On kdone: if rnd==0, state<=state^rkey; else state<=rf_result.
//     - If rnd==NR -> DONE; else rnd<=rnd+1 -> KREQ.
// - DONE
//   - out_valid=1; ct stable.
//   - On out_ready -> IDLE. in_ready rises the cycle after the handshake; no same-cycle re-accept.
// - in_ready=1 only in IDLE. in_valid while busy is ignored; pt is not sampled.
// - rf_last=(rnd==NR), combinational from rnd; rf_state=state register.
// - Latency, with key_exp done one cycle after en:
//   - 2 cycles per round.
//   - Accept to out_valid: 1+2*(NR+1) = 23 cycles for NR=10.
// - rnd wraps never; it saturates at NR, and the next accept clears it.
// - out_valid holds indefinitely under backpressure; state and ct are frozen.
// CONFIGURATION
// - AES_KEY_TIMEOUT_EN defined:
//   - A 6-bit counter runs in KWAIT.
//   - If KEY_TIMEOUT cycles pass without kdone: err<=1, state<=0, -> IDLE. No out_valid is produced.
//   - The counter clears on entry to KREQ.
// - AES_KEY_TIMEOUT_EN undefined:
//   - KWAIT waits forever; no counter logic.
//   - err is tied 0.
// TESTING
// - FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734
//   -> ct 3925841d02dc09fbdc118597196a0b32.
// - FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff
//   -> ct 69c4e0d86a7b0430d8cdb78070b4c55a.
//   - out_valid exactly 23 cycles after accept, with 1-cycle key model.
// - Key stall: key model delays kdone 5 cycles in round 4
//   -> same ct; out_valid 4 cycles later than baseline; key_en pulses exactly 11 times, kcnt 0..10 in order.
// - Backpressure: out_ready low for 10 cycles after out_valid
//   -> ct stable, in_ready=0, second in_valid ignored; out_ready=1 -> IDLE, next pt accepted.
// - Reset mid-op: rst pulse during round 6
//   -> all outputs 0 and in_ready=1 next cycle; a fresh App.B run then gives the correct ct.
// - AES_KEY_TIMEOUT_EN: kdone never asserted in round 3
//   -> err=1 after 32 KWAIT cycles, back in IDLE, out_valid never rises; next accept clears err.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES encryption sequencer.
//
// Takes a plaintext block, fetches the NR+1 round keys one at a time from
// key_exp and steps the 128-bit state through an external combinational
// round function. Round 0 is a plain AddRoundKey. Rounds 1..NR take the
// round function's result, which is given the current state and round key.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   plaintext handshake; pt is sampled on accept
//   pt                  128-bit plaintext
//   key_en              one-cycle round-key request to key_exp
//   kcnt                round index presented to key_exp (0..NR)
//   kdone, rkey         key_exp done flag and round key (valid while kdone)
//   rf_state            current state register, to the round function
//   rf_last             final round marker (round function skips MixColumns)
//   rf_result           round function output
//   out_valid/out_ready ciphertext handshake
//   ct                  ciphertext (the state register while in DONE)
//   err                 key timeout flag, sticky until the next accept
//
// Build option
//   AES_KEY_TIMEOUT_EN  when defined, KWAIT aborts after KEY_TIMEOUT cycles
//                       without kdone: err is set, the state is cleared and
//                       the FSM returns to IDLE. When undefined, KWAIT waits
//                       indefinitely and err is tied low.
//
// state | meaning
// IDLE  | ready for plaintext
// KREQ  | pulse key_en for round rnd
// KWAIT | wait for kdone, then update the state register
// DONE  | ciphertext presented until out_ready

module aes_round_ctrl #(
  parameter int NR          = 10,
  parameter int KEY_TIMEOUT = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt,
  output logic         key_en,
  output logic [3:0]   kcnt,
  input  logic         kdone,
  input  logic [127:0] rkey,
  output logic [127:0] rf_state,
  output logic         rf_last,
  input  logic [127:0] rf_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KREQ  = 2'd1,
    KWAIT = 2'd2,
    DONE  = 2'd3
  } fsm_t;

  localparam logic [3:0] LAST_RND = 4'(NR);

  if (!(NR == 10 || NR == 12 || NR == 14) || KEY_TIMEOUT < 1 || KEY_TIMEOUT > 64)
  begin : g_bad_params
    $error("aes_round_ctrl: NR must be 10/12/14 and KEY_TIMEOUT 1..64");
  end

  fsm_t         fsm, fsm_nxt;
  logic [127:0] state_q, state_nxt;
  logic [3:0]   rnd, rnd_nxt;

`ifdef AES_KEY_TIMEOUT_EN
  // Down-counter loaded in KREQ; hitting zero in KWAIT without kdone
  // marks the KEY_TIMEOUT-th waiting cycle.
  localparam logic [5:0] TMO_LOAD = 6'(KEY_TIMEOUT - 1);
  logic [5:0] tmo, tmo_nxt;
  logic       err_q, err_nxt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm     <= IDLE;
      state_q <= '0;
      rnd     <= '0;
`ifdef AES_KEY_TIMEOUT_EN
      tmo     <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      fsm     <= fsm_nxt;
      state_q <= state_nxt;
      rnd     <= rnd_nxt;
`ifdef AES_KEY_TIMEOUT_EN
      tmo     <= tmo_nxt;
      err_q   <= err_nxt;
`endif
    end
  end

  always_comb begin
    fsm_nxt   = fsm;
    state_nxt = state_q;
    rnd_nxt   = rnd;
    in_ready  = 1'b0;
    key_en    = 1'b0;
    out_valid = 1'b0;
`ifdef AES_KEY_TIMEOUT_EN
    tmo_nxt   = tmo;
    err_nxt   = err_q;
`endif
    case (fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = pt;
          rnd_nxt   = '0;
`ifdef AES_KEY_TIMEOUT_EN
          err_nxt   = 1'b0;
`endif
          fsm_nxt   = KREQ;
        end
      end
      KREQ: begin
        // kdone seen here is left over from the previous round's key.
        key_en  = 1'b1;
`ifdef AES_KEY_TIMEOUT_EN
        tmo_nxt = TMO_LOAD;
`endif
        fsm_nxt = KWAIT;
      end
      KWAIT: begin
        if (kdone) begin
          if (rnd == 4'd0) begin
            state_nxt = state_q ^ rkey;
          end else begin
            state_nxt = rf_result;
          end
          if (rnd == LAST_RND) begin
            fsm_nxt = DONE;
          end else begin
            rnd_nxt = rnd + 4'd1;
            fsm_nxt = KREQ;
          end
        end
`ifdef AES_KEY_TIMEOUT_EN
        else if (tmo == 6'd0) begin
          err_nxt   = 1'b1;
          state_nxt = '0;
          fsm_nxt   = IDLE;
        end else begin
          tmo_nxt = tmo - 6'd1;
        end
`endif
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_nxt = IDLE;
        end
      end
      default: begin
        fsm_nxt = IDLE;
      end
    endcase
  end

  assign kcnt     = rnd;
  assign rf_last  = (rnd == LAST_RND);
  assign rf_state = state_q;
  assign ct       = state_q;

`ifdef AES_KEY_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl. Provides a behavioural key_exp
// (round keys precomputed from the current key, done one cycle after en,
// done held high until the next en, optional stall/never rounds) and a
// behavioural AES round function driving rf_result.

module tb_aes_round_ctrl;

  localparam int NR = 10;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] pt;
  logic         key_en;
  logic [3:0]   kcnt;
  logic         kdone;
  logic [127:0] rkey;
  logic [127:0] rf_state;
  logic         rf_last;
  logic [127:0] rf_result;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ct;
  logic         err;

  int total = 0;
  int bad   = 0;

  aes_round_ctrl #(.NR(NR), .KEY_TIMEOUT(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pt        (pt),
    .key_en    (key_en),
    .kcnt      (kcnt),
    .kdone     (kdone),
    .rkey      (rkey),
    .rf_state  (rf_state),
    .rf_last   (rf_last),
    .rf_result (rf_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ct        (ct),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- AES reference helpers ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    logic [7:0] r;
    logic [7:0] t;
    logic [7:0] s;
    x = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      x = gmul(x, x);
      r = gmul(r, x);
    end
    t = r;
    s = r;
    for (int i = 0; i < 4; i++) begin
      t = {t[6:0], t[7]};
      s = s ^ t;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] st,
                                             input logic [127:0] k,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   o [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) b[i] = sbox(st[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[r+4*c] = b[r + 4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = o[4*c]; a1 = o[4*c+1]; a2 = o[4*c+2]; a3 = o[4*c+3];
        o[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        o[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        o[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        o[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = o[i];
    return res ^ k;
  endfunction

  assign rf_result = aes_round(rf_state, rkey, rf_last);

  logic [127:0] rk [0:10];

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]) ^ rcon, sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- key_exp model ----------------
  logic [3:0] stall_rnd = 4'hf;
  logic [3:0] never_rnd = 4'hf;
  logic [2:0] kleft;
  logic [3:0] kidx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      kdone <= 1'b0;
      rkey  <= '0;
      kleft <= '0;
      kidx  <= '0;
    end else if (key_en) begin
      if (kcnt == never_rnd) begin
        kdone <= 1'b0;
        kleft <= '0;
      end else if (kcnt == stall_rnd) begin
        kdone <= 1'b0;
        kleft <= 3'd4;
        kidx  <= kcnt;
      end else begin
        kdone <= 1'b1;
        rkey  <= rk[kcnt];
      end
    end else if (kleft != 3'd0) begin
      kleft <= kleft - 3'd1;
      if (kleft == 3'd1) begin
        kdone <= 1'b1;
        rkey  <= rk[kidx];
      end
    end
  end

  // ---------------- monitors ----------------
  logic [3:0] ken_log [$];
  int ov_cnt  = 0;
  int err_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (key_en) ken_log.push_back(kcnt);
      if (out_valid) ov_cnt++;
      if (err) err_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- check / step tasks ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_in_ready"},  128'(in_ready),  128'd1);
    chk({tag, "_key_en"},    128'(key_en),    128'd0);
    chk({tag, "_out_valid"}, 128'(out_valid), 128'd0);
    chk({tag, "_kcnt"},      128'(kcnt),      128'd0);
    chk({tag, "_rf_last"},   128'(rf_last),   128'd0);
    chk({tag, "_rf_state"},  rf_state,        128'd0);
    chk({tag, "_ct"},        ct,              128'd0);
    chk({tag, "_err"},       128'(err),       128'd0);
  endtask

  // Accepts p and runs to out_valid; leaves the DUT in DONE.
  task automatic run_block(input logic [127:0] p, input logic [127:0] exp_ct,
                           input int exp_lat, input bit busy_valid, input string tag);
    int wait_n;
    int lat;
    int log0;
    int n;
    wait_n = 0;
    while (!in_ready && wait_n < 50) begin
      @(posedge clk); @(negedge clk); wait_n++;
    end
    chk({tag, "_ready"}, 128'(in_ready), 128'd1);
    log0     = ken_log.size();
    in_valid = 1'b1;
    pt       = p;
    lat      = 0;
    @(posedge clk); lat++; @(negedge clk);
    chk({tag, "_err_clr"}, 128'(err), 128'd0);
    chk({tag, "_busy"}, 128'(in_ready), 128'd0);
    pt       = ~p;
    in_valid = busy_valid;
    while (!out_valid && lat < 200) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    in_valid = 1'b0;
    chk({tag, "_out_valid"}, 128'(out_valid), 128'd1);
    chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    chk({tag, "_ct"}, ct, exp_ct);
    chk({tag, "_rf_last"}, 128'(rf_last), 128'd1);
    n = ken_log.size() - log0;
    chk({tag, "_key_en_pulses"}, 128'(n), 128'(NR + 1));
    for (int i = 0; i < n && i <= NR; i++)
      chk({tag, "_kcnt_order"}, 128'(ken_log[log0+i]), 128'(i));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_rel_in_ready"}, 128'(in_ready), 128'd1);
    chk({tag, "_rel_out_valid"}, 128'(out_valid), 128'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int log0;
    int ov0;
    int cyc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pt        = '0;
    expand_key(KEY_B);
    #1;
    chk_idle_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 App.B
    run_block(PT_B, CT_B, 23, 1'b0, "appb");
    release_out("appb");

    // FIPS-197 C.1
    expand_key(KEY_C);
    run_block(PT_C, CT_C, 23, 1'b0, "c1");
    release_out("c1");

    // Key stall in round 4, in_valid held high with junk pt while busy
    expand_key(KEY_B);
    stall_rnd = 4'd4;
    run_block(PT_B, CT_B, 27, 1'b1, "stall");
    stall_rnd = 4'hf;
    release_out("stall");

    // Backpressure
    run_block(PT_B, CT_B, 23, 1'b0, "bp");
    expand_key(KEY_C);
    in_valid = 1'b1;
    pt       = PT_C;
    log0     = ken_log.size();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      chk("bp_ct_hold", ct, CT_B);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
    end
    chk("bp_no_key_req", 128'(ken_log.size() - log0), 128'd0);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle_after_hs", 128'(in_ready), 128'd1);
    chk("bp_no_same_cycle_accept", 128'(key_en), 128'd0);
    run_block(PT_C, CT_C, 23, 1'b0, "bp_next");
    release_out("bp_next");

    // Reset during round 6
    expand_key(KEY_B);
    in_valid = 1'b1;
    pt       = PT_B;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!(key_en && kcnt == 4'd6) && n < 100) begin
      @(posedge clk); @(negedge clk); n++;
    end
    chk("rst_reach_round6", 128'(kcnt), 128'd6);
    rst = 1'b1;
    #1;
    chk_idle_zero("rst_mid");
    @(negedge clk);
    chk("rst_mid_hold_ready", 128'(in_ready), 128'd1);
    rst = 1'b0;
    @(negedge clk);
    run_block(PT_B, CT_B, 23, 1'b0, "after_rst");
    release_out("after_rst");

`ifdef AES_KEY_TIMEOUT_EN
    // kdone never arrives in round 3
    never_rnd = 4'd3;
    ov0       = ov_cnt;
    in_valid  = 1'b1;
    pt        = PT_B;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!(key_en && kcnt == 4'd3) && n < 50) begin
      @(posedge clk); @(negedge clk); n++;
    end
    chk("tmo_reach_round3", 128'(kcnt), 128'd3);
    cyc = 0;
    while (!err && cyc < 100) begin
      @(posedge clk); cyc++; @(negedge clk);
    end
    chk("tmo_err", 128'(err), 128'd1);
    chk("tmo_cycles", 128'(cyc), 128'd33);
    chk("tmo_idle", 128'(in_ready), 128'd1);
    chk("tmo_state_clr", rf_state, 128'd0);
    chk("tmo_no_out_valid", 128'(ov_cnt - ov0), 128'd0);
    never_rnd = 4'hf;
    run_block(PT_B, CT_B, 23, 1'b0, "tmo_next");
    release_out("tmo_next");
`else
    ov0 = 0;
    cyc = 0;
    chk("err_never_set", 128'(err_cnt + ov0 + cyc), 128'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
